usr_param: RTL

Parametrised universal shift register, the next generation of the team's 4-bit USR. It adds a WIDTH parameter, rotate and arithmetic-shift modes, a registered serial-out bit, and a counted burst mode: one start request performs N shift steps, one per clock, under a busy/done handshake. It sits wherever a datapath needs parallel load, serial stream-in/stream-out or multi-position shifts, such as serialisers, CRC/LFSR preload or bit-field alignment.

---
 rtl/usr_param_if.sv | 27 ++
 rtl/usr_param.sv | 133 +++++++++++++
 2 files changed

// File: rtl/usr_param_if.sv
// Handshake/bus bundle for the parametrised universal shift register.
// The master drives the controls; the slave (the register) returns the state and status.
interface usr_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) ();
    logic [2:0]       op;
    logic             start;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] par_in;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output op, start, amount, par_in, sin_l, sin_r,
        input  q, sout, busy, done
    );

    modport slave (
        input  op, start, amount, par_in, sin_l, sin_r,
        output q, sout, busy, done
    );
endinterface

// File: rtl/usr_param.sv
// Parametrised universal shift register.
// Supports single-step ops and counted bursts of one shift/rotate op under a busy/done handshake.
module usr_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    usr_param_if.slave  bus
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_SHL   = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_lat_q, op_lat_d;

    logic [WIDTH:0]   idle_step_c;
    logic [WIDTH:0]   run_step_c;

    function automatic logic is_shift(input logic [2:0] o);
        return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ROL) ||
               (o == OP_ROR) || (o == OP_ASR);
    endfunction

    // Returns {sout_next, q_next} for one execution of op o.
    function automatic logic [WIDTH:0] step(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] cur,
        input logic             so,
        input logic             sl,
        input logic             sr,
        input logic [WIDTH-1:0] pin
    );
        logic [WIDTH:0] r;
        case (o)
            OP_HOLD:  r = {so, cur};
            OP_SHL:   r = {cur[WIDTH-1], cur[WIDTH-2:0], sl};
            OP_SHR:   r = {cur[0], sr, cur[WIDTH-1:1]};
            OP_LOAD:  r = {so, pin};
            OP_ROL:   r = {cur[WIDTH-1], cur[WIDTH-2:0], cur[WIDTH-1]};
            OP_ROR:   r = {cur[0], cur[0], cur[WIDTH-1:1]};
            OP_ASR:   r = {cur[0], cur[WIDTH-1], cur[WIDTH-1:1]};
            OP_CLEAR: r = '0;
            default:  r = {so, cur};
        endcase
        return r;
    endfunction

    assign idle_step_c = step(bus.op, q_q, sout_q, bus.sin_l, bus.sin_r, bus.par_in);
    assign run_step_c  = step(op_lat_q, q_q, sout_q, bus.sin_l, bus.sin_r, bus.par_in);

    // State register; reset wins over any burst in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            q_q      <= '0;
            sout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            op_lat_q <= OP_HOLD;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            sout_q   <= sout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            op_lat_q <= op_lat_d;
        end
    end

    // Next-state and datapath selection.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        sout_d   = sout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        op_lat_d = op_lat_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && is_shift(bus.op)) begin
                    if (bus.amount != '0) begin
                        op_lat_d = bus.op;
                        cnt_d    = bus.amount;
                        busy_d   = 1'b1;
                        state_d  = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    {sout_d, q_d} = idle_step_c;
                end
            end
            ST_RUN: begin
                {sout_d, q_d} = run_step_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.q    = q_q;
    assign bus.sout = sout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
